// File: rtl/elevator.sv
// Three-floor elevator controller.
// Latches floor calls, picks a travel direction (up wins from idle) and holds
// the door open for DOOR_CYCLES clocks at each served floor. A floor sensor
// value of 3 means the car is between floors; nothing is served or cleared then.
module elevator #(
  parameter int DOOR_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] floor_req,
  input  logic [1:0] current_floor,
  output logic       direction,
  output logic       door_open
);

  localparam int TW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [2:0]      pending_r;
  logic [2:0]      pending_s;
  logic [TW-1:0]   timer_r;
  logic [TW-1:0]   timer_s;
  logic            dir_r;
  logic            dir_s;

  logic [2:0]      all_req_s;
  logic [2:0]      here_mask_s;
  logic            floor_valid_s;
  logic            req_here_s;
  logic            new_req_here_s;
  logic            req_above_s;
  logic            req_below_s;

  // Decode the combined request set relative to the sensed car position.
  always_comb begin
    all_req_s     = pending_r | floor_req;
    floor_valid_s = 1'b1;
    here_mask_s   = 3'b000;
    req_above_s   = 1'b0;
    req_below_s   = 1'b0;
    case (current_floor)
      2'd0: begin
        here_mask_s = 3'b001;
        req_above_s = |all_req_s[2:1];
      end
      2'd1: begin
        here_mask_s = 3'b010;
        req_above_s = all_req_s[2];
        req_below_s = all_req_s[0];
      end
      2'd2: begin
        here_mask_s = 3'b100;
        req_below_s = |all_req_s[1:0];
      end
      default: begin
        floor_valid_s = 1'b0;
      end
    endcase
    req_here_s     = |(all_req_s & here_mask_s);
    new_req_here_s = |(floor_req & here_mask_s);
  end

  // Next-state, door timer, direction and pending-request computation.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    dir_s   = dir_r;
    case (state_r)
      ST_IDLE: begin
        if (req_here_s) begin
          state_s = ST_DOOR_OPEN;
          timer_s = TIMER_LOAD;
        end else if (req_above_s) begin
          state_s = ST_MOVE_UP;
          dir_s   = 1'b1;
        end else if (req_below_s) begin
          state_s = ST_MOVE_DOWN;
          dir_s   = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MOVE_UP: begin
        if (!floor_valid_s) begin
          state_s = ST_MOVE_UP;
        end else if (req_here_s) begin
          state_s = ST_DOOR_OPEN;
          timer_s = TIMER_LOAD;
        end else if (!req_above_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_MOVE_UP;
        end
      end
      ST_MOVE_DOWN: begin
        if (!floor_valid_s) begin
          state_s = ST_MOVE_DOWN;
        end else if (req_here_s) begin
          state_s = ST_DOOR_OPEN;
          timer_s = TIMER_LOAD;
        end else if (!req_below_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_MOVE_DOWN;
        end
      end
      ST_DOOR_OPEN: begin
        // A fresh call for this floor keeps the door open for a full dwell.
        if (new_req_here_s) begin
          timer_s = TIMER_LOAD;
        end else if (timer_r == '0) begin
          state_s = ST_IDLE;
        end else begin
          timer_s = timer_r - TW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        timer_s = '0;
      end
    endcase
    // The floor being served is dropped, including a call arriving this edge.
    if (state_r == ST_DOOR_OPEN) begin
      pending_s = all_req_s & ~here_mask_s;
    end else begin
      pending_s = all_req_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Pending requests, door timer and held travel direction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_r <= 3'b000;
      timer_r   <= '0;
      dir_r     <= 1'b0;
    end else begin
      pending_r <= pending_s;
      timer_r   <= timer_s;
      dir_r     <= dir_s;
    end
  end

  // Actuator outputs decoded straight from registers.
  always_comb begin
    door_open = (state_r == ST_DOOR_OPEN);
    direction = dir_r;
  end

endmodule

// File: tb/tb_elevator.sv
// Self-checking bench for the elevator controller: directed scenarios plus a
// randomized run, all compared against a behavioural model of the car.
module tb_elevator;

  localparam int DOOR_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] floor_req;
  logic [1:0] current_floor;
  logic       direction;
  logic       door_open;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending calls, remaining door-open cycles (0 = closed),
  // motion (-1 down, 0 stopped, +1 up) and last travel direction.
  bit m_pend [3];
  int m_door_left;
  int m_moving;
  bit m_dir;

  elevator #(.DOOR_CYCLES(DOOR_CYCLES)) dut (
    .clk           (clk),
    .rst           (rst),
    .floor_req     (floor_req),
    .current_floor (current_floor),
    .direction     (direction),
    .door_open     (door_open)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
    m_door_left = 0;
    m_moving    = 0;
    m_dir       = 1'b0;
  endtask

  // One clock edge of the car as described by its rules.
  task automatic model_step(input logic [2:0] req, input logic [1:0] cf);
    bit r [3];
    bit valid;
    bit above;
    bit below;
    bit here;
    bit new_here;
    int f;
    f     = int'(cf);
    valid = (f < 3);
    above = 1'b0;
    below = 1'b0;
    here  = 1'b0;
    new_here = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r[i] = m_pend[i] | req[i];
      if (valid && r[i] && i > f) above = 1'b1;
      if (valid && r[i] && i < f) below = 1'b1;
      if (valid && i == f) begin
        here     = r[i];
        new_here = req[i];
      end
    end
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = r[i] && !(m_door_left > 0 && valid && i == f);
    end
    if (m_door_left > 0) begin
      if (new_here) m_door_left = DOOR_CYCLES;
      else          m_door_left = m_door_left - 1;
    end else if (!valid) begin
      m_door_left = 0;
    end else if (here) begin
      m_door_left = DOOR_CYCLES;
      m_moving    = 0;
    end else if (m_moving == 1) begin
      if (!above) m_moving = 0;
    end else if (m_moving == -1) begin
      if (!below) m_moving = 0;
    end else if (above) begin
      m_moving = 1;
      m_dir    = 1'b1;
    end else if (below) begin
      m_moving = -1;
      m_dir    = 1'b0;
    end
  endtask

  task automatic step(input logic [2:0] req, input logic [1:0] cf, input string tag);
    floor_req     = req;
    current_floor = cf;
    @(posedge clk);
    model_step(req, cf);
    #1;
    check_eq({tag, ".door"}, door_open, (m_door_left > 0) ? 1 : 0);
    check_eq({tag, ".dir"}, direction, m_dir);
  endtask

  // Asynchronous reset pulse issued between clock edges.
  task automatic pulse_reset(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    check_eq({tag, ".rst_door"}, door_open, 0);
    check_eq({tag, ".rst_dir"}, direction, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] rq;
    logic [1:0] cf;
    rst           = 1'b0;
    floor_req     = 3'b000;
    current_floor = 2'd0;
    model_reset();
    #3;
    check_eq("reset.door", door_open, 0);
    check_eq("reset.dir", direction, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    repeat (3) step(3'b000, 2'd0, "idle");

    // Move up to floor 2.
    step(3'b100, 2'd0, "up_req");
    check_eq("up_dir_set", direction, 1);
    step(3'b100, 2'd0, "up_req");
    step(3'b000, 2'd1, "up_pass");
    check_eq("up_no_door", door_open, 0);
    step(3'b000, 2'd2, "up_arrive");
    check_eq("up_door1", door_open, 1);
    step(3'b000, 2'd2, "up_dwell");
    check_eq("up_door2", door_open, 1);
    step(3'b000, 2'd2, "up_close");
    check_eq("up_closed", door_open, 0);
    check_eq("up_dir_held", direction, 1);
    repeat (2) step(3'b000, 2'd2, "up_idle");

    // Move down to floor 0.
    step(3'b001, 2'd2, "dn_req");
    check_eq("dn_dir_set", direction, 0);
    step(3'b000, 2'd1, "dn_pass");
    step(3'b000, 2'd0, "dn_arrive");
    repeat (3) step(3'b000, 2'd0, "dn_dwell");

    // Call at the current floor.
    step(3'b010, 2'd1, "here_req");
    check_eq("here_door", door_open, 1);
    repeat (3) step(3'b000, 2'd1, "here_dwell");

    // Multi-stop trip from floor 0.
    repeat (2) step(3'b000, 2'd0, "ms_settle");
    step(3'b110, 2'd0, "ms_req");
    step(3'b000, 2'd1, "ms_stop1");
    repeat (3) step(3'b000, 2'd1, "ms_dwell1");
    step(3'b000, 2'd2, "ms_stop2");
    repeat (4) step(3'b000, 2'd2, "ms_dwell2");

    // Door reopen by a repeated call while open.
    step(3'b100, 2'd2, "reopen_req");
    step(3'b000, 2'd2, "reopen_a");
    step(3'b100, 2'd2, "reopen_b");
    repeat (3) step(3'b000, 2'd2, "reopen_c");

    // Between-floors sensor value while moving up.
    repeat (4) step(3'b000, 2'd0, "inv_settle");
    step(3'b100, 2'd0, "inv_req");
    repeat (3) step(3'b000, 2'd3, "inv_hold");
    check_eq("inv_dir_held", direction, 1);
    step(3'b000, 2'd2, "inv_arrive");
    repeat (3) step(3'b000, 2'd2, "inv_dwell");

    // Reset while the door is open with another call still pending.
    repeat (2) step(3'b000, 2'd1, "rst_settle");
    step(3'b110, 2'd1, "rst_req");
    step(3'b000, 2'd1, "rst_open");
    pulse_reset("rst_mid");
    repeat (3) step(3'b000, 2'd1, "rst_after");
    check_eq("rst_pending_lost", direction, 0);

    // Randomized traffic with occasional resets.
    cf = 2'd0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        pulse_reset("rnd");
      end else begin
        rq = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        if ($urandom_range(0, 9) < 3) cf = 2'($urandom_range(0, 3));
        step(rq, cf, "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
